// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bus for the MIPS memory-access stage.
// The master side is the execute stage and hazard unit. The slave side is mem_stage.
interface mem_stage_if #(
  parameter int INST_SZ    = 32,
  parameter int MEM_ADDR_W = 8
);
  logic [INST_SZ-1:0]    i_alu_result_E;
  logic [INST_SZ-1:0]    i_write_data_E;
  logic [INST_SZ-1:0]    i_branch_delay_slot_E;
  logic                  i_mem_read;
  logic                  i_mem_write;
  logic [1:0]            i_mem_width;
  logic                  i_mem_unsigned;
  logic                  i_mem_to_reg;
  logic                  i_bds_sel;
  logic                  i_reg_write;
  logic [4:0]            i_write_reg;
  logic                  i_stall;
  logic                  i_flush;
  logic [MEM_ADDR_W-1:0] i_debug_addr;

  logic [INST_SZ-1:0]    o_debug_data;
  logic [INST_SZ-1:0]    o_alu_result_M;
  logic [INST_SZ-1:0]    o_read_data_M;
  logic [INST_SZ-1:0]    o_branch_delay_slot_M;
  logic                  o_mem_to_reg_W;
  logic                  o_bds_sel_W;
  logic                  o_reg_write_W;
  logic [4:0]            o_write_reg_W;
  logic                  o_misaligned_W;

  modport master (
    output i_alu_result_E, i_write_data_E, i_branch_delay_slot_E,
           i_mem_read, i_mem_write, i_mem_width, i_mem_unsigned,
           i_mem_to_reg, i_bds_sel, i_reg_write, i_write_reg,
           i_stall, i_flush, i_debug_addr,
    input  o_debug_data, o_alu_result_M, o_read_data_M, o_branch_delay_slot_M,
           o_mem_to_reg_W, o_bds_sel_W, o_reg_write_W, o_write_reg_W,
           o_misaligned_W
  );

  modport slave (
    input  i_alu_result_E, i_write_data_E, i_branch_delay_slot_E,
           i_mem_read, i_mem_write, i_mem_width, i_mem_unsigned,
           i_mem_to_reg, i_bds_sel, i_reg_write, i_write_reg,
           i_stall, i_flush, i_debug_addr,
    output o_debug_data, o_alu_result_M, o_read_data_M, o_branch_delay_slot_M,
           o_mem_to_reg_W, o_bds_sel_W, o_reg_write_W, o_write_reg_W,
           o_misaligned_W
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: little-endian byte-addressable data memory plus the MEM/WB register.
// Defining MEM_ALIGN_CHECK_EN flags misaligned half/word accesses and suppresses them.
module mem_stage #(
  parameter int INST_SZ    = 32,
  parameter int MEM_ADDR_W = 8
) (
  input logic        i_clk,
  input logic        i_rst_n,
  mem_stage_if.slave bus
);

  localparam int DEPTH = 1 << MEM_ADDR_W;
  localparam int LANES = INST_SZ / 8;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_RSVD = 2'b10,
    WIDTH_WORD = 2'b11
  } mem_width_e;

  typedef struct packed {
    logic [INST_SZ-1:0] alu_result;
    logic [INST_SZ-1:0] read_data;
    logic [INST_SZ-1:0] branch_delay_slot;
    logic               mem_to_reg;
    logic               bds_sel;
    logic               reg_write;
    logic [4:0]         write_reg;
    logic               misaligned;
  } memwb_t;

  logic [INST_SZ-1:0]    mem [DEPTH];
  logic [MEM_ADDR_W-1:0] word_idx;
  logic [1:0]            off;
  mem_width_e            width;
  logic [INST_SZ-1:0]    rd_word;
  logic [INST_SZ-1:0]    rd_shift;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [INST_SZ-1:0]    ld_data;
  logic [INST_SZ-1:0]    st_data;
  logic [LANES-1:0]      st_be;
  logic                  misaligned;
  logic                  store_en;
  memwb_t                memwb_d;
  memwb_t                memwb_q;

  assign word_idx = bus.i_alu_result_E[MEM_ADDR_W+1:2];
  assign off      = bus.i_alu_result_E[1:0];
  assign width    = mem_width_e'(bus.i_mem_width);

  assign rd_word           = mem[word_idx];
  assign bus.o_debug_data  = mem[bus.i_debug_addr];

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (bus.i_mem_read || bus.i_mem_write) begin
      case (width)
        WIDTH_BYTE: misaligned = 1'b0;
        WIDTH_HALF: misaligned = off[0];
        default:    misaligned = (off != 2'b00);
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  // Replicate the store field across all lanes; the byte enables pick the lanes that land.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    st_be   = '1;
    st_data = bus.i_write_data_E;
    case (width)
      WIDTH_BYTE: begin
        st_be   = LANES'(1) << off;
        st_data = {LANES{bus.i_write_data_E[7:0]}};
      end
      WIDTH_HALF: begin
        st_be   = off[1] ? 4'b1100 : 4'b0011;
        st_data = {(LANES/2){bus.i_write_data_E[15:0]}};
      end
      default: begin
        st_be   = '1;
        st_data = bus.i_write_data_E;
      end
    endcase
  end

  // Reset low at the edge suppresses an in-flight store even though the array itself is not reset.
  assign store_en = bus.i_mem_write && !bus.i_stall && !bus.i_flush && !misaligned && i_rst_n;

  // NOTE: the memory array has no reset, so it can map onto RAM macros.
  always_ff @(posedge i_clk) begin
    if (store_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (st_be[k]) begin
          mem[word_idx][8*k +: 8] <= st_data[8*k +: 8];
        end
      end
    end
  end

  assign rd_shift = rd_word >> {off, 3'b000};
  assign ld_byte  = rd_shift[7:0];
  assign ld_half  = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = '0;
    if (bus.i_mem_read) begin
      case (width)
        WIDTH_BYTE: ld_data = bus.i_mem_unsigned ? {{(INST_SZ-8){1'b0}}, ld_byte}
                                                 : {{(INST_SZ-8){ld_byte[7]}}, ld_byte};
        WIDTH_HALF: ld_data = bus.i_mem_unsigned ? {{(INST_SZ-16){1'b0}}, ld_half}
                                                 : {{(INST_SZ-16){ld_half[15]}}, ld_half};
        default:    ld_data = rd_word;
      endcase
    end
  end

  always_comb begin
    memwb_d                   = '0;
    memwb_d.alu_result        = bus.i_alu_result_E;
    memwb_d.read_data         = ld_data;
    memwb_d.branch_delay_slot = bus.i_branch_delay_slot_E;
    memwb_d.mem_to_reg        = bus.i_mem_to_reg;
    memwb_d.bds_sel           = bus.i_bds_sel;
    memwb_d.reg_write         = bus.i_reg_write && !misaligned;
    memwb_d.write_reg         = bus.i_write_reg;
    memwb_d.misaligned        = misaligned;
  end

  // Flush outranks stall so a bubble can be inserted into a frozen stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!i_rst_n) begin
      memwb_q <= '0;
    end else if (bus.i_flush) begin
      memwb_q <= '0;
    end else if (!bus.i_stall) begin
      memwb_q <= memwb_d;
    end
  end

  assign bus.o_alu_result_M        = memwb_q.alu_result;
  assign bus.o_read_data_M         = memwb_q.read_data;
  assign bus.o_branch_delay_slot_M = memwb_q.branch_delay_slot;
  assign bus.o_mem_to_reg_W        = memwb_q.mem_to_reg;
  assign bus.o_bds_sel_W           = memwb_q.bds_sel;
  assign bus.o_reg_write_W         = memwb_q.reg_write;
  assign bus.o_write_reg_W         = memwb_q.write_reg;
  assign bus.o_misaligned_W        = memwb_q.misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-cycle accesses, then stall, flush,
// misalignment and reset sequences. Expectations follow MEM_ALIGN_CHECK_EN when defined.
module tb_mem_stage;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b11;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bds;
    logic        rd;
    logic        wr;
    logic [1:0]  width;
    logic        uns;
    logic        m2r;
    logic        bsel;
    logic        rw;
    logic [4:0]  wreg;
    logic [7:0]  dbg;
    logic [31:0] exp_rd;
    logic [31:0] exp_dbg;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  mem_stage_if #(.INST_SZ(32), .MEM_ADDR_W(8)) bus ();

  mem_stage #(.INST_SZ(32), .MEM_ADDR_W(8)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic [31:0] addr, logic [31:0] wdata, logic [31:0] bds,
                              logic rd, logic wr, logic [1:0] width, logic uns,
                              logic m2r, logic bsel, logic rw, logic [4:0] wreg,
                              logic [7:0] dbg, logic [31:0] exp_rd, logic [31:0] exp_dbg);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.bds = bds; v.rd = rd; v.wr = wr;
    v.width = width; v.uns = uns; v.m2r = m2r; v.bsel = bsel; v.rw = rw;
    v.wreg = wreg; v.dbg = dbg; v.exp_rd = exp_rd; v.exp_dbg = exp_dbg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] alu, input logic [31:0] rdd,
                            input logic [31:0] bds, input logic m2r, input logic bsel,
                            input logic rw, input logic [4:0] wreg, input logic mis);
    check({tag, " alu"},   bus.o_alu_result_M,        alu);
    check({tag, " rdata"}, bus.o_read_data_M,         rdd);
    check({tag, " bds"},   bus.o_branch_delay_slot_M, bds);
    check({tag, " m2r"},   32'(bus.o_mem_to_reg_W),   32'(m2r));
    check({tag, " bsel"},  32'(bus.o_bds_sel_W),      32'(bsel));
    check({tag, " rw"},    32'(bus.o_reg_write_W),    32'(rw));
    check({tag, " wreg"},  32'(bus.o_write_reg_W),    32'(wreg));
    check({tag, " mis"},   32'(bus.o_misaligned_W),   32'(mis));
  endtask

  task automatic drive(input vec_t v);
    bus.i_alu_result_E        = v.addr;
    bus.i_write_data_E        = v.wdata;
    bus.i_branch_delay_slot_E = v.bds;
    bus.i_mem_read            = v.rd;
    bus.i_mem_write           = v.wr;
    bus.i_mem_width           = v.width;
    bus.i_mem_unsigned        = v.uns;
    bus.i_mem_to_reg          = v.m2r;
    bus.i_bds_sel             = v.bsel;
    bus.i_reg_write           = v.rw;
    bus.i_write_reg           = v.wreg;
    bus.i_debug_addr          = v.dbg;
    bus.i_stall               = 1'b0;
    bus.i_flush               = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [31:0] exp_dbg4_h, exp_dbg4_w;
    logic        exp_mis, exp_rw;

    // addr, wdata, bds, rd, wr, width, uns, m2r, bsel, rw, wreg, dbg, exp_rd, exp_dbg
    vecs.push_back(mk(32'h40, 32'h0,        32'h4,  0, 1, W, 0, 0, 0, 0, 5'd0,  8'd16, 32'h0,        32'h0));
    vecs.push_back(mk(32'h30, 32'h0,        32'h4,  0, 1, W, 0, 0, 0, 0, 5'd0,  8'd12, 32'h0,        32'h0));
    vecs.push_back(mk(32'h10, 32'hDEADBEEF, 32'h8,  0, 1, W, 0, 0, 0, 0, 5'd0,  8'd4,  32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(32'h10, 32'h0,        32'hC,  1, 0, W, 0, 1, 0, 1, 5'd2,  8'd4,  32'hDEADBEEF, 32'hDEADBEEF));
    vecs.push_back(mk(32'h20, 32'h0,        32'h10, 0, 1, W, 0, 0, 0, 0, 5'd0,  8'd8,  32'h0,        32'h0));
    vecs.push_back(mk(32'h21, 32'h12345680, 32'h14, 0, 1, B, 0, 0, 0, 0, 5'd0,  8'd8,  32'h0,        32'h00008000));
    vecs.push_back(mk(32'h21, 32'h0,        32'h18, 1, 0, B, 0, 1, 0, 1, 5'd3,  8'd8,  32'hFFFFFF80, 32'h00008000));
    vecs.push_back(mk(32'h21, 32'h0,        32'h1C, 1, 0, B, 1, 1, 0, 1, 5'd4,  8'd8,  32'h00000080, 32'h00008000));
    vecs.push_back(mk(32'h20, 32'h0,        32'h20, 1, 0, H, 1, 1, 0, 1, 5'd5,  8'd8,  32'h00008000, 32'h00008000));
    vecs.push_back(mk(32'h20, 32'h0,        32'h24, 1, 0, H, 0, 1, 0, 1, 5'd6,  8'd8,  32'hFFFF8000, 32'h00008000));
    vecs.push_back(mk(32'h22, 32'hAAAACAFE, 32'h28, 0, 1, H, 0, 0, 0, 0, 5'd0,  8'd8,  32'h0,        32'hCAFE8000));
    vecs.push_back(mk(32'h20, 32'h0,        32'h2C, 1, 0, W, 0, 1, 0, 1, 5'd7,  8'd8,  32'hCAFE8000, 32'hCAFE8000));
    vecs.push_back(mk(32'h23, 32'h0,        32'h30, 1, 0, B, 1, 1, 0, 1, 5'd8,  8'd8,  32'h000000CA, 32'hCAFE8000));
    vecs.push_back(mk(32'h22, 32'h0,        32'h34, 1, 0, H, 0, 1, 0, 1, 5'd9,  8'd8,  32'hFFFFCAFE, 32'hCAFE8000));
    vecs.push_back(mk(32'h20, 32'h0,        32'h38, 1, 0, 2'b10, 0, 1, 0, 1, 5'd10, 8'd8, 32'hCAFE8000, 32'hCAFE8000));
    vecs.push_back(mk(32'h10000010, 32'h0,  32'h3C, 1, 0, W, 0, 1, 0, 1, 5'd11, 8'd4,  32'hDEADBEEF, 32'hDEADBEEF));
    vecs.push_back(mk(32'h10, 32'h0,        32'h40, 0, 0, W, 0, 0, 0, 1, 5'd12, 8'd4,  32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(32'h10, 32'h0,  32'h00400008, 1, 0, W, 0, 1, 1, 1, 5'd31, 8'd4,  32'hDEADBEEF, 32'hDEADBEEF));

    // Reset state, held across two edges.
    rst_n = 1'b0;
    v = mk(32'h0, 32'h0, 32'h0, 0, 0, W, 0, 0, 0, 0, 5'd0, 8'd0, 32'h0, 32'h0);
    drive(v);
    tick();
    tick();
    check_outs("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 0);
    #3 rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rd, vecs[i].bds,
                 vecs[i].m2r, vecs[i].bsel, vecs[i].rw && 1'b1, vecs[i].wreg, 1'b0);
      check($sformatf("vec%0d dbg", i), bus.o_debug_data, vecs[i].exp_dbg);
    end

    // Store to word 16 held under stall for three edges: no write, outputs frozen.
    drive(mk(32'h40, 32'h55, 32'h44, 0, 1, W, 0, 0, 0, 0, 5'd0, 8'd16, 32'h0, 32'h0));
    bus.i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outs($sformatf("stall%0d", k), 32'h10, 32'hDEADBEEF, 32'h00400008, 1, 1, 1, 5'd31, 0);
      check($sformatf("stall%0d dbg", k), bus.o_debug_data, 32'h0);
    end
    bus.i_stall = 1'b0;
    tick();
    check_outs("stall_rel", 32'h40, 32'h0, 32'h44, 0, 0, 0, 5'd0, 0);
    check("stall_rel dbg", bus.o_debug_data, 32'h55);

    // Flush (also with stall) zeroes outputs and drops the store.
    drive(mk(32'h10, 32'h0, 32'h48, 1, 0, W, 0, 1, 1, 1, 5'd7, 8'd16, 32'h0, 32'h0));
    tick();
    check_outs("pre_flush", 32'h10, 32'hDEADBEEF, 32'h48, 1, 1, 1, 5'd7, 0);
    drive(mk(32'h40, 32'h77, 32'h4C, 1, 1, W, 0, 1, 1, 1, 5'd8, 8'd16, 32'h0, 32'h0));
    bus.i_flush = 1'b1;
    bus.i_stall = 1'b1;
    tick();
    check_outs("flush", 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 0);
    check("flush dbg", bus.o_debug_data, 32'h55);

`ifdef MEM_ALIGN_CHECK_EN
    exp_dbg4_h = 32'hDEADBEEF;
    exp_dbg4_w = 32'hDEADBEEF;
    exp_mis    = 1'b1;
    exp_rw     = 1'b0;
`else
    exp_dbg4_h = 32'hDEAD1234;
    exp_dbg4_w = 32'hA5A5A5A5;
    exp_mis    = 1'b0;
    exp_rw     = 1'b1;
`endif
    drive(mk(32'h11, 32'h00001234, 32'h50, 0, 1, H, 0, 0, 0, 1, 5'd10, 8'd4, 32'h0, 32'h0));
    tick();
    check_outs("mis_half", 32'h11, 32'h0, 32'h50, 0, 0, exp_rw, 5'd10, exp_mis);
    check("mis_half dbg", bus.o_debug_data, exp_dbg4_h);
    drive(mk(32'h13, 32'hA5A5A5A5, 32'h54, 0, 1, W, 0, 0, 0, 1, 5'd11, 8'd4, 32'h0, 32'h0));
    tick();
    check_outs("mis_word", 32'h13, 32'h0, 32'h54, 0, 0, exp_rw, 5'd11, exp_mis);
    check("mis_word dbg", bus.o_debug_data, exp_dbg4_w);

    // Asynchronous reset mid-cycle, then a store presented while reset is held.
    #2 rst_n = 1'b0;
    #1;
    check_outs("async_rst", 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 0);
    drive(mk(32'h30, 32'h11111111, 32'h58, 0, 1, W, 0, 1, 1, 1, 5'd12, 8'd12, 32'h0, 32'h0));
    tick();
    check_outs("rst_store", 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 0);
    check("rst_store dbg", bus.o_debug_data, 32'h0);
    #3 rst_n = 1'b1;
    drive(mk(32'h30, 32'h0, 32'h5C, 1, 0, W, 0, 1, 0, 1, 5'd13, 8'd12, 32'h0, 32'h0));
    tick();
    check_outs("post_rst", 32'h30, 32'h0, 32'h5C, 1, 0, 1, 5'd13, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
